// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module  : spi_slave
// Brief   : SPI mode-0 byte slave with CPU register port, clk-domain oversampled.
// Revision: 1.0 - initial release
// ============================================================================
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] spis_datain,
  output logic [15:0] spis_dataout,
  input  logic        spis_wrh_n,
  input  logic        spis_wrl_n,
  input  logic        spis_rdh_n,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        cs_n,
  output logic        miso,
  output logic        miso_oe,
  output logic        irq
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEL  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sync_vld;
  logic                   r_sclk_d;
  logic                   r_cs_d;
  logic                   r_armed;

  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx_shift;
  logic [7:0] r_tx_shift;
  logic [7:0] r_tx_hold;
  logic       r_tx_valid;
  logic [7:0] r_rx_data;
  logic       r_rx_full;
  logic       r_overrun;
  logic       r_irq_en;
  logic       r_irq;

  logic       w_sclk_s, w_mosi_s, w_cs_s;
  logic       w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
  logic       w_sel_entry, w_sel_exit, w_active;
  logic       w_bit_rise, w_bit_fall, w_byte_done, w_tx_load;
  logic [7:0] w_tx_next;
  logic       w_wr_tx, w_wr_ctl, w_rd_ack;
  logic [7:0] w_status;
  logic       w_unused;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  assign w_cs_rise   = w_cs_s & ~r_cs_d;
  assign w_cs_fall   = ~w_cs_s & r_cs_d;

  // Reset values in the cs_n chain are not real pin samples; the slave only
  // arms once it has seen the pin genuinely high after the chain has filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sync_vld  <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
      r_armed     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_sync_vld  <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
      if (r_sync_vld[SYNC_STAGES-1] && w_cs_s)
        r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_cs_fall && r_armed) w_state_nxt = ST_SEL;
      ST_SEL:  if (w_cs_rise)            w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_sel_entry = (r_state == ST_IDLE) && (w_state_nxt == ST_SEL);
  assign w_sel_exit  = (r_state == ST_SEL)  && (w_state_nxt == ST_IDLE);
  assign w_active    = (r_state == ST_SEL)  && (w_state_nxt == ST_SEL);
  assign w_bit_rise  = w_active & w_sclk_rise;
  assign w_bit_fall  = w_active & w_sclk_fall;
  assign w_byte_done = w_bit_rise && (r_bit_cnt == 3'd7);
  assign w_tx_load   = w_sel_entry || (w_bit_fall && (r_bit_cnt == 3'd0));
  assign w_tx_next   = r_tx_valid ? r_tx_hold : 8'hFF;
  assign w_wr_tx     = ~spis_wrh_n;
  assign w_wr_ctl    = ~spis_wrl_n;
  assign w_rd_ack    = ~spis_rdh_n;
  assign w_unused    = ^spis_datain[7:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= 7'd0;
      r_tx_shift <= 8'd0;
      r_tx_hold  <= 8'd0;
      r_tx_valid <= 1'b0;
      r_rx_data  <= 8'd0;
      r_rx_full  <= 1'b0;
      r_overrun  <= 1'b0;
      r_irq_en   <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (w_sel_entry || w_sel_exit) begin
        r_bit_cnt  <= 3'd0;
        r_rx_shift <= 7'd0;
      end else if (w_bit_rise) begin
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        r_rx_shift <= {r_rx_shift[5:0], w_mosi_s};
      end

      if (w_tx_load)       r_tx_shift <= w_tx_next;
      else if (w_bit_fall) r_tx_shift <= {r_tx_shift[6:0], 1'b0};

      // A write in the load cycle wins: the loader took the old byte.
      if (w_wr_tx) begin
        r_tx_hold  <= spis_datain[15:8];
        r_tx_valid <= 1'b1;
      end else if (w_tx_load) begin
        r_tx_valid <= 1'b0;
      end

      if (w_wr_ctl) begin
        r_irq_en <= spis_datain[0];
        if (spis_datain[1]) r_overrun <= 1'b0;
      end

      if (w_byte_done) begin
        r_rx_data <= {r_rx_shift, w_mosi_s};
        r_rx_full <= 1'b1;
        if (r_rx_full && !w_rd_ack) r_overrun <= 1'b1;
      end else if (w_rd_ack) begin
        r_rx_full <= 1'b0;
      end

      r_irq <= r_irq_en & (r_rx_full | r_overrun);
    end
  end

  assign w_status = {2'b00, r_irq_en, (r_state == ST_SEL), (r_bit_cnt != 3'd0),
                     r_overrun, ~r_tx_valid, r_rx_full};

  assign spis_dataout = {r_rx_data, w_status};
  assign miso         = (r_state == ST_SEL) ? r_tx_shift[7] : 1'b0;
  assign miso_oe      = (r_state == ST_SEL);
  assign irq          = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_slave
// Brief   : Directed self-checking bench for spi_slave (mode 0, half-period 8 clk).
// Revision: 1.0 - initial release
// ============================================================================
module tb_spi_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] spis_datain;
  logic [15:0] spis_dataout;
  logic        spis_wrh_n, spis_wrl_n, spis_rdh_n;
  logic        sclk, mosi, cs_n;
  logic        miso, miso_oe, irq;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] got;

  always #5 clk = ~clk;

  spi_slave #(.SYNC_STAGES(2)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spis_datain  (spis_datain),
    .spis_dataout (spis_dataout),
    .spis_wrh_n   (spis_wrh_n),
    .spis_wrl_n   (spis_wrl_n),
    .spis_rdh_n   (spis_rdh_n),
    .sclk         (sclk),
    .mosi         (mosi),
    .cs_n         (cs_n),
    .miso         (miso),
    .miso_oe      (miso_oe),
    .irq          (irq)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_wrh(input logic [7:0] b);
    spis_datain = {b, 8'h00};
    spis_wrh_n  = 1'b0;
    clk_wait(1);
    spis_wrh_n  = 1'b1;
  endtask

  task automatic cpu_wrl(input logic [15:0] d);
    spis_datain = d;
    spis_wrl_n  = 1'b0;
    clk_wait(1);
    spis_wrl_n  = 1'b1;
  endtask

  task automatic cpu_rdh();
    spis_rdh_n = 1'b0;
    clk_wait(1);
    spis_rdh_n = 1'b1;
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    clk_wait(8);
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    clk_wait(8);
  endtask

  // ack_last pulses rdh in the clk cycle where the slave registers the last bit
  // (3rd rising clk edge after the sclk pin change with two sync stages).
  task automatic spi_bits(input logic [7:0] d, input int n, input bit ack_last,
                          output logic [7:0] rcv);
    rcv = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = d[7-i];
      clk_wait(8);
      sclk = 1'b1;
      rcv  = {rcv[6:0], miso};
      if (ack_last && (i == n - 1)) begin
        clk_wait(2);
        spis_rdh_n = 1'b0;
        clk_wait(1);
        spis_rdh_n = 1'b1;
        clk_wait(5);
      end else begin
        clk_wait(8);
      end
      sclk = 1'b0;
    end
    clk_wait(8);
  endtask

  initial begin
    rst_n       = 1'b0;
    spis_datain = 16'h0000;
    spis_wrh_n  = 1'b1;
    spis_wrl_n  = 1'b1;
    spis_rdh_n  = 1'b1;
    sclk        = 1'b0;
    mosi        = 1'b0;
    cs_n        = 1'b1;
    clk_wait(3);
    check("rst_dataout", spis_dataout, 16'h0002);
    check("rst_miso",    miso,         1'b0);
    check("rst_oe",      miso_oe,      1'b0);
    check("rst_irq",     irq,          1'b0);
    rst_n = 1'b1;
    clk_wait(10);

    // tx byte A5 out while master sends 3C
    cpu_wrh(8'hA5);
    check("tx_loaded_empty", spis_dataout[1], 1'b0);
    cs_low();
    check("sel_oe",  miso_oe,         1'b1);
    check("sel_bit", spis_dataout[4], 1'b1);
    spi_bits(8'h3C, 8, 1'b0, got);
    check("a5_miso",     got,          8'hA5);
    check("3c_sel_stat", spis_dataout, 16'h3C13);
    cs_high();
    check("3c_idle_stat", spis_dataout, 16'h3C03);
    check("idle_oe",      miso_oe,      1'b0);
    check("idle_miso",    miso,         1'b0);
    cpu_rdh();
    check("ack_clears", spis_dataout, 16'h3C02);

    // no tx data: all ones
    cs_low();
    spi_bits(8'h96, 8, 1'b0, got);
    cs_high();
    check("ff_miso",   got,          8'hFF);
    check("96_status", spis_dataout, 16'h9603);
    cpu_rdh();

    // overrun with irq enabled
    cpu_wrl(16'h0001);
    cs_low();
    spi_bits(8'h11, 8, 1'b0, got);
    spi_bits(8'h22, 8, 1'b0, got);
    cs_high();
    check("ovr_status", spis_dataout, 16'h2227);
    check("ovr_irq",    irq,          1'b1);
    cpu_wrl(16'h0003);
    clk_wait(2);
    check("ovr_cleared", spis_dataout, 16'h2223);
    check("irq_rxfull",  irq,          1'b1);
    cpu_rdh();
    clk_wait(2);
    check("irq_drop",   irq,          1'b0);
    check("after_ack",  spis_dataout, 16'h2222);
    cpu_wrl(16'h0000);

    // aborted partial byte then full byte
    cs_low();
    spi_bits(8'hF0, 4, 1'b0, got);
    check("busy_mid", spis_dataout[3], 1'b1);
    cs_high();
    check("partial_discard", spis_dataout, 16'h2202);
    cs_low();
    spi_bits(8'h5A, 8, 1'b0, got);
    cs_high();
    check("5a_status", spis_dataout, 16'h5A03);

    // ack exactly on completion of the next byte
    cs_low();
    spi_bits(8'hC6, 8, 1'b1, got);
    cs_high();
    check("ack_same_cycle", spis_dataout, 16'hC603);

    // reset mid-byte
    cpu_wrl(16'h0001);
    clk_wait(2);
    check("pre_rst_irq", irq, 1'b1);
    cs_low();
    spi_bits(8'h81, 4, 1'b0, got);
    rst_n = 1'b0;
    #1;
    check("mid_rst_dataout", spis_dataout, 16'h0002);
    check("mid_rst_miso",    miso,         1'b0);
    check("mid_rst_oe",      miso_oe,      1'b0);
    check("mid_rst_irq",     irq,          1'b0);
    clk_wait(3);
    rst_n = 1'b1;
    clk_wait(10);
    check("cs_low_at_rst_idle", miso_oe,         1'b0);
    check("cs_low_at_rst_sel",  spis_dataout[4], 1'b0);
    cs_high();
    cs_low();
    spi_bits(8'hE7, 8, 1'b0, got);
    cs_high();
    check("post_rst_miso", got,          8'hFF);
    check("post_rst_rx",   spis_dataout, 16'hE703);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter: SYNC_STAGES, 2, synchronizer depth on sclk/mosi/cs_n (legal 2..3).
REQ-002 SHALL have port: clk  in  1  single system clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: spis_datain  in  16  CPU write data; [15:8] tx byte, [7:0] control.
REQ-005 SHALL have port: spis_dataout  out  16  [15:8] rx byte, [7:0] status.
REQ-006 SHALL have port: spis_wrh_n  in  1  active-low, one clk per write; loads tx holding register.
REQ-007 SHALL have port: spis_wrl_n  in  1  active-low, one clk per write; control write.
REQ-008 SHALL have port: spis_rdh_n  in  1  active-low, one clk per read; acknowledges rx byte.
REQ-009 SHALL have port: sclk  in  1  SPI clock from master, asynchronous to clk.
REQ-010 SHALL have port: mosi  in  1  serial data from master.
REQ-011 SHALL have port: cs_n  in  1  active-low select from master.
REQ-012 SHALL have port: miso  out  1  serial data to master.
REQ-013 SHALL have port: miso_oe  out  1  miso output enable for pad tristate.
REQ-014 SHALL have port: irq  out  1  active-high interrupt, level.

Function
REQ-015 SHALL synchronize sclk, mosi, cs_n through SYNC_STAGES flops and edge-detect sclk/cs_n on synchronized values with one extra history flop.
REQ-016 SHALL implement SPI mode 0, MSB first: sample mosi on sclk rising edge, advance miso on sclk falling edge.
REQ-017 SHALL operate correctly when sclk high and low times each >= SYNC_STAGES+2 clk periods; faster sclk is unsupported.
REQ-018 SHALL have states IDLE (cs_n sync high) and SEL (cs_n sync low); IDLE->SEL on cs_n falling, SEL->IDLE on cs_n rising.
REQ-019 SHALL on IDLE->SEL: load tx shift register from holding register if tx_valid (then clear tx_valid), else with 8'hFF; clear 3-bit bit counter.
REQ-020 SHALL drive miso = tx_shift[7] and miso_oe = 1 in SEL; miso = 0, miso_oe = 0 in IDLE.
REQ-021 SHALL on each sclk rising in SEL: rx_shift <= {rx_shift[6:0], mosi_sync}; bit counter increments modulo 8.
REQ-022 SHALL on the rising edge with counter == 7: rx_data <= completed byte, rx_full <= 1; if rx_full already 1 and not acked same cycle, overrun <= 1.
REQ-023 SHALL on sclk falling in SEL: if counter == 0 (byte boundary), reload tx shift as REQ-019; else shift tx_shift left by 1.
REQ-024 SHALL on cs_n rising mid-byte discard partial rx bits, clear counter, leave rx_data/rx_full/overrun unchanged.
REQ-025 SHALL on spis_wrh_n low: tx_hold <= spis_datain[15:8], tx_valid <= 1; a write while tx_valid overwrites (last write wins).
REQ-026 SHALL, when a tx write coincides with a shift-register load, load the pre-write tx_hold/tx_valid; the new byte remains held with tx_valid = 1.
REQ-027 SHALL on spis_wrl_n low: irq_en <= spis_datain[0]; spis_datain[1] = 1 clears overrun; other bits ignored.
REQ-028 SHALL on spis_rdh_n low clear rx_full; if a byte completes the same cycle, rx_full stays 1 with new rx_data and no overrun.
REQ-029 SHALL present status combinationally: [0] rx_full, [1] ~tx_valid, [2] overrun, [3] busy (counter != 0), [4] SEL, [5] irq_en, [7:6] 0.
REQ-030 SHALL drive irq = irq_en & (rx_full | overrun), registered.
REQ-031 SHALL assert rx_full no later than SYNC_STAGES+2 clk after the 8th sclk rising edge at the pin.

Reset
REQ-032 SHALL on rst_n low asynchronously set: sync flops to cs_n=1, sclk=0, mosi=0; state IDLE; counter 0; shift registers, tx_hold, rx_data 0; tx_valid, rx_full, overrun, irq_en 0.
REQ-033 SHALL present after reset: spis_dataout = 16'h0002, miso = 0, miso_oe = 0, irq = 0.
REQ-034 SHALL treat rst_n deassertion with cs_n already low as IDLE until a fresh cs_n falling edge.

Verification
REQ-035 SHALL cover: write 8'hA5 via wrh, master sends 8'h3C with sclk half-period 8 clk -> miso bits 1,0,1,0,0,1,0,1; dataout = 16'h3C01 + SEL bit after byte; tx_empty = 1.
REQ-036 SHALL cover: no tx write, select and clock one byte -> miso all ones (8'hFF), status tx_empty stays 1.
REQ-037 SHALL cover: two bytes 8'h11, 8'h22 with no rdh between -> rx_data = 8'h22, overrun = 1, irq = 1 when irq_en = 1; control write 16'h0003 clears overrun, irq follows rx_full.
REQ-038 SHALL cover: cs_n deasserted after 4 sclk edges, then full byte 8'h5A -> rx_data = 8'h5A, no spurious rx_full from partial byte.
REQ-039 SHALL cover: rdh pulse in exact cycle byte completes -> rx_full = 1, overrun = 0.
REQ-040 SHALL cover: rst_n asserted mid-byte -> all outputs at REQ-033 values within same cycle, next byte after new cs_n falling received correctly.
